// File: rtl/local_out_buffer_if.sv
// Handshake bundle between the router local output port, the output buffer and the collector.
// The buffer uses the slave modport; the router/collector side uses master.
interface local_out_buffer_if #(
  parameter int dataWidth = 32,
  parameter int ptrWidth  = 2
);
  logic [dataWidth-1:0] PacketIn;
  logic                 ReqUpStr;
  logic                 GntUpStr;
  logic                 UpStrFull;
  logic [dataWidth-1:0] PacketOut;
  logic                 ReqDnStr;
  logic                 GntDnStr;
  logic                 DnStrFull;
  logic [ptrWidth:0]    Count;

  modport slave (
    input  PacketIn, ReqUpStr, GntDnStr, DnStrFull,
    output GntUpStr, UpStrFull, PacketOut, ReqDnStr, Count
  );

  modport master (
    output PacketIn, ReqUpStr, GntDnStr, DnStrFull,
    input  GntUpStr, UpStrFull, PacketOut, ReqDnStr, Count
  );
endinterface

// File: rtl/local_out_buffer.sv
// Circular FIFO between a router local output port and a packet collector.
// Upstream and downstream sides each run a small request/grant FSM.
module local_out_buffer #(
  parameter int dataWidth   = 32,
  parameter int bufferDepth = 4,
  parameter int ptrWidth    = 2
) (
  input logic              clk,
  input logic              reset,
  local_out_buffer_if.slave bus
);

  typedef enum logic {U_WAIT, U_GNT} upState_t;
  typedef enum logic {D_IDLE, D_REQ} dnState_t;

  logic [dataWidth-1:0] mem [bufferDepth];
  logic [ptrWidth-1:0]  wrPtr;
  logic [ptrWidth-1:0]  rdPtr;
  logic [ptrWidth:0]    count;
  logic [ptrWidth:0]    countNext;
  logic                 upFull;
  logic                 gntUp;
  logic                 reqDn;
  logic                 reqDnNext;
  logic                 pushEn;
  logic                 popEn;
  upState_t             upState;
  upState_t             upNext;
  dnState_t             dnState;
  dnState_t             dnNext;

  // Upstream: a request is ignored while the previous grant is still showing.
  always_comb begin
    upNext = upState;
    pushEn = 1'b0;
    case (upState)
      U_WAIT: begin
        if (bus.ReqUpStr && !upFull) begin
          pushEn = 1'b1;
          upNext = U_GNT;
        end
      end
      U_GNT:   upNext = U_WAIT;
      default: upNext = U_WAIT;
    endcase
  end

  // Downstream: once raised, the request is held until granted, even if DnStrFull rises.
  always_comb begin
    dnNext    = dnState;
    reqDnNext = reqDn;
    popEn     = 1'b0;
    case (dnState)
      D_IDLE: begin
        if ((count != '0) && !bus.DnStrFull) begin
          reqDnNext = 1'b1;
          dnNext    = D_REQ;
        end
      end
      D_REQ: begin
        if (bus.GntDnStr) begin
          popEn     = 1'b1;
          reqDnNext = 1'b0;
          dnNext    = D_IDLE;
        end
      end
      default: begin
        reqDnNext = 1'b0;
        dnNext    = D_IDLE;
      end
    endcase
  end

  always_comb begin
    countNext = count;
    case ({pushEn, popEn})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upState <= U_WAIT;
      dnState <= D_IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      upFull  <= 1'b0;
      gntUp   <= 1'b0;
      reqDn   <= 1'b0;
    end else begin
      upState <= upNext;
      dnState <= dnNext;
      gntUp   <= pushEn;
      reqDn   <= reqDnNext;
      count   <= countNext;
      upFull  <= (countNext == (ptrWidth + 1)'(bufferDepth));
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= bus.PacketIn;
  end

  assign bus.GntUpStr  = gntUp;
  assign bus.UpStrFull = upFull;
  assign bus.ReqDnStr  = reqDn;
  assign bus.PacketOut = mem[rdPtr];
  assign bus.Count     = count;

endmodule

// File: tb/tb_local_out_buffer.sv
// Bench for local_out_buffer: directed and random traffic against a queue-based model of the
// buffer, plus a collector-side log of delivered packets checked for order.
module tb_local_out_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  local_out_buffer_if #(.dataWidth(DW), .ptrWidth(PW)) bus ();

  local_out_buffer #(.dataWidth(DW), .bufferDepth(DEPTH), .ptrWidth(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int passCnt = 0;
  int totalCnt = 0;

  logic [DW-1:0] mQ[$];
  logic          mGnt;
  logic          mFull;
  logic          mReq;
  logic [DW-1:0] delivered[$];
  int            reqAge;
  logic          dnFull;
  int            gntMode;   // 0 never, 1 one cycle after request, 2 random, 3 always

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic req, input logic [DW-1:0] data);
    logic          gnt;
    logic          reqSeen;
    logic          push;
    logic          pop;
    logic [DW-1:0] outSeen;
    int            sizeBefore;
    case (gntMode)
      0:       gnt = 1'b0;
      1:       gnt = (reqAge >= 2);
      2:       gnt = 1'($urandom_range(0, 1));
      default: gnt = 1'b1;
    endcase
    bus.ReqUpStr  = req;
    bus.PacketIn  = data;
    bus.GntDnStr  = gnt;
    bus.DnStrFull = dnFull;
    reqSeen = bus.ReqDnStr;
    outSeen = bus.PacketOut;
    @(posedge clk);
    if (reqSeen && gnt) delivered.push_back(outSeen);
    sizeBefore = mQ.size();
    push = req && !mFull && !mGnt;
    pop  = mReq && gnt;
    if (pop) void'(mQ.pop_front());
    if (push) mQ.push_back(data);
    mGnt  = push;
    mFull = (mQ.size() == DEPTH);
    if (mReq) mReq = !gnt;
    else      mReq = (sizeBefore != 0) && !dnFull;
    #1;
    check("GntUpStr", 32'(bus.GntUpStr), 32'(mGnt));
    check("UpStrFull", 32'(bus.UpStrFull), 32'(mFull));
    check("ReqDnStr", 32'(bus.ReqDnStr), 32'(mReq));
    check("Count", 32'(bus.Count), 32'(mQ.size()));
    if (mReq && mQ.size() > 0) check("PacketOut", bus.PacketOut, mQ[0]);
    reqAge = bus.ReqDnStr ? reqAge + 1 : 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic          reqUp;
    logic [DW-1:0] nextVal;
    bus.ReqUpStr = 1'b0; bus.PacketIn = '0; bus.GntDnStr = 1'b0; bus.DnStrFull = 1'b0;
    dnFull = 1'b0; gntMode = 0; reqAge = 0;
    mGnt = 1'b0; mFull = 1'b0; mReq = 1'b0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.GntUpStr), 0);
    check("rst_full", 32'(bus.UpStrFull), 0);
    check("rst_req", 32'(bus.ReqDnStr), 0);
    check("rst_count", 32'(bus.Count), 0);
    @(negedge clk) reset = 1'b0;
    repeat (5) step(1'b0, '0);

    // single packet with a collector granting one cycle after the request
    gntMode = 1; delivered.delete();
    step(1'b1, 32'h0000_ABCD);
    check("sp_gnt", 32'(bus.GntUpStr), 1);
    check("sp_count", 32'(bus.Count), 1);
    step(1'b0, '0);
    check("sp_req", 32'(bus.ReqDnStr), 1);
    check("sp_out", bus.PacketOut, 32'h0000_ABCD);
    repeat (6) step(1'b0, '0);
    check("sp_ndel", 32'(delivered.size()), 1);
    if (delivered.size() > 0) check("sp_del", delivered[0], 32'h0000_ABCD);
    check("sp_end_count", 32'(bus.Count), 0);

    // fill under back-pressure, fifth request waits for space
    dnFull = 1'b1; gntMode = 0; delivered.delete();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, DW'(k));
      step(1'b0, '0);
    end
    check("fill_full", 32'(bus.UpStrFull), 1);
    check("fill_count", 32'(bus.Count), 4);
    repeat (3) begin
      step(1'b1, 32'd5);
      check("fill_nognt", 32'(bus.GntUpStr), 0);
    end
    dnFull = 1'b0; gntMode = 1;
    reqUp = 1'b1;
    for (int i = 0; i < 40 && reqUp; i++) begin
      step(1'b1, 32'd5);
      if (bus.GntUpStr) reqUp = 1'b0;
    end
    check("fill_gnt5_seen", 32'(reqUp), 0);
    repeat (25) step(1'b0, '0);
    check("fill_ndel", 32'(delivered.size()), 5);
    for (int i = 0; i < delivered.size() && i < 5; i++) check("fill_order", delivered[i], 32'(i + 1));

    // full buffer, collector grant coincides with an upstream request
    dnFull = 1'b1; gntMode = 0; delivered.delete();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h10 + 32'(k));
      step(1'b0, '0);
    end
    dnFull = 1'b0;
    step(1'b0, '0);
    check("same_req", 32'(bus.ReqDnStr), 1);
    gntMode = 3;
    step(1'b1, 32'h14);
    gntMode = 0;
    step(1'b1, 32'h14);
    check("same_gnt", 32'(bus.GntUpStr), 1);
    check("same_count", 32'(bus.Count), 4);
    gntMode = 1;
    repeat (25) step(1'b0, '0);
    check("same_ndel", 32'(delivered.size()), 5);
    for (int i = 0; i < delivered.size() && i < 5; i++) check("same_order", delivered[i], 32'h10 + 32'(i));

    // random stream of 0..9 with random back-pressure and random grants
    gntMode = 2; delivered.delete(); nextVal = '0;
    for (int i = 0; i < 800 && delivered.size() < 10; i++) begin
      dnFull = 1'($urandom_range(0, 1));
      step((nextVal < 10) && ($urandom_range(0, 3) != 0), nextVal);
      if (bus.GntUpStr) nextVal = nextVal + 1;
    end
    check("strm_ndel", 32'(delivered.size()), 10);
    for (int i = 0; i < delivered.size() && i < 10; i++) check("strm_order", delivered[i], 32'(i));
    dnFull = 1'b0; gntMode = 1;
    repeat (4) step(1'b0, '0);

    // reset in the middle of a downstream request
    dnFull = 1'b1; gntMode = 0; delivered.delete();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h21 + 32'(k));
      step(1'b0, '0);
    end
    dnFull = 1'b0;
    step(1'b0, '0);
    check("mrst_req_before", 32'(bus.ReqDnStr), 1);
    check("mrst_count_before", 32'(bus.Count), 3);
    #2 reset = 1'b1;
    #1;
    check("mrst_req", 32'(bus.ReqDnStr), 0);
    check("mrst_count", 32'(bus.Count), 0);
    check("mrst_gnt", 32'(bus.GntUpStr), 0);
    check("mrst_full", 32'(bus.UpStrFull), 0);
    mQ.delete(); mGnt = 1'b0; mFull = 1'b0; mReq = 1'b0; reqAge = 0;
    @(negedge clk) reset = 1'b0;
    gntMode = 1;
    step(1'b1, 32'h1234);
    repeat (8) step(1'b0, '0);
    check("mrst_ndel", 32'(delivered.size()), 1);
    if (delivered.size() > 0) check("mrst_first", delivered[0], 32'h1234);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
